// File: rtl/network_sequencer.sv
// Purpose: sequences one fully-connected layer by streaming bias and weight words
//          from flash, reading activations, driving a LANES-wide MAC and writing
//          one result per neuron.
// Ports:   clk/rst (sync, active-high); start/abort control; layer config
//          (num_inputs, num_neurons, weight_base, in_base, out_base); flash
//          req/valid/addr/data; activation read/write ports; MAC weights/inputs/
//          bias/clear/accumulate/mac_result; busy/done status.
module network_sequencer #(
  parameter int LANES   = 4,
  parameter int DATA_W  = 4,
  parameter int FADDR_W = 16,
  parameter int AADDR_W = 5,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [CNT_W-1:0]          num_inputs,
  input  logic [CNT_W-1:0]          num_neurons,
  input  logic [FADDR_W-1:0]        weight_base,
  input  logic [AADDR_W-1:0]        in_base,
  input  logic [AADDR_W-1:0]        out_base,
  output logic                      flash_req,
  output logic [FADDR_W-1:0]        flash_addr,
  input  logic                      flash_valid,
  input  logic [LANES*DATA_W-1:0]   flash_data,
  output logic [AADDR_W-1:0]        act_rd_addr,
  input  logic [LANES*DATA_W-1:0]   act_rd_data,
  output logic                      act_wr_en,
  output logic [AADDR_W-1:0]        act_wr_addr,
  output logic [DATA_W-1:0]         act_wr_data,
  output logic [LANES*DATA_W-1:0]   weights,
  output logic [LANES*DATA_W-1:0]   inputs,
  output logic [DATA_W-1:0]         bias,
  output logic                      clear,
  output logic                      accumulate,
  input  logic [DATA_W-1:0]         mac_result,
  output logic                      busy,
  output logic                      done
);

  // Wide enough for chunk*LANES + lane without overflow.
  localparam int IW = CNT_W + $clog2(LANES) + 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_BIAS, ST_FETCH, ST_ACCUM, ST_WRITE, ST_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          n_q, n_d, k_q, k_d, chunks_q, chunks_d;
  logic [CNT_W-1:0]          ninp_q, ninp_d, nneu_q, nneu_d;
  logic [AADDR_W-1:0]        in_base_q, in_base_d, out_base_q, out_base_d;
  logic [FADDR_W-1:0]        flash_addr_q, flash_addr_d;
  logic [LANES*DATA_W-1:0]   weights_q, weights_d;
  logic [DATA_W-1:0]         bias_q, bias_d;
  logic                      bias_first_q, bias_first_d;
  logic                      wr_phase_q, wr_phase_d;
  logic                      zero_q, zero_d;

  logic [LANES-1:0]          lane_ok;
  logic [LANES*DATA_W-1:0]   w_masked, x_masked;

  // A lane carries real data only while its global input index is below
  // num_inputs; this is only ever false on the last chunk.
  always_comb begin
    lane_ok  = '0;
    w_masked = '0;
    x_masked = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_ok[i] = (IW'(k_q) * IW'(LANES) + IW'(i)) < IW'(ninp_q);
      w_masked[i*DATA_W +: DATA_W] = lane_ok[i] ? weights_q[i*DATA_W +: DATA_W] : '0;
      x_masked[i*DATA_W +: DATA_W] = lane_ok[i] ? act_rd_data[i*DATA_W +: DATA_W] : '0;
    end
  end

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    k_d          = k_q;
    chunks_d     = chunks_q;
    ninp_d       = ninp_q;
    nneu_d       = nneu_q;
    in_base_d    = in_base_q;
    out_base_d   = out_base_q;
    flash_addr_d = flash_addr_q;
    weights_d    = weights_q;
    bias_d       = bias_q;
    wr_phase_d   = 1'b0;
    zero_d       = zero_q;

    flash_req   = 1'b0;
    act_rd_addr = '0;
    act_wr_en   = 1'b0;
    act_wr_addr = '0;
    act_wr_data = '0;
    weights     = '0;
    inputs      = '0;
    clear       = 1'b0;
    accumulate  = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          ninp_d       = num_inputs;
          nneu_d       = num_neurons;
          in_base_d    = in_base;
          out_base_d   = out_base;
          flash_addr_d = weight_base;
          n_d          = '0;
          k_d          = '0;
          chunks_d     = CNT_W'((IW'(num_inputs) + IW'(LANES - 1)) / IW'(LANES));
          zero_d       = (num_inputs == '0) || (num_neurons == '0);
          state_d      = ST_BIAS;
        end
      end
      ST_BIAS: begin
        // An empty layer is recognised from the captured config and leaves
        // without touching flash or activation memory.
        if (zero_q) begin
          state_d = ST_DONE;
        end else begin
          flash_req   = 1'b1;
          clear       = bias_first_q;
          act_rd_addr = in_base_q + AADDR_W'(k_q);
          if (flash_valid) begin
            bias_d       = flash_data[DATA_W-1:0];
            flash_addr_d = flash_addr_q + FADDR_W'(1);
            state_d      = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        flash_req   = 1'b1;
        act_rd_addr = in_base_q + AADDR_W'(k_q);
        if (flash_valid) begin
          weights_d    = flash_data;
          flash_addr_d = flash_addr_q + FADDR_W'(1);
          state_d      = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        accumulate = 1'b1;
        weights    = w_masked;
        inputs     = x_masked;
        k_d        = k_q + CNT_W'(1);
        state_d    = (k_q == chunks_q - CNT_W'(1)) ? ST_WRITE : ST_FETCH;
      end
      ST_WRITE: begin
        // First cycle waits for the MAC pipeline; second cycle commits.
        if (!wr_phase_q) begin
          wr_phase_d = 1'b1;
        end else begin
          act_wr_en   = 1'b1;
          act_wr_addr = out_base_q + AADDR_W'(n_q);
          act_wr_data = mac_result;
          n_d         = n_q + CNT_W'(1);
          k_d         = '0;
          state_d     = (n_q == nneu_q - CNT_W'(1)) ? ST_DONE : ST_BIAS;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything, including a flash word arriving this cycle.
    if (abort && (state_q != ST_IDLE)) begin
      state_d      = ST_IDLE;
      n_d          = n_q;
      k_d          = k_q;
      flash_addr_d = flash_addr_q;
      weights_d    = weights_q;
      bias_d       = bias_q;
      wr_phase_d   = 1'b0;
      flash_req    = 1'b0;
      act_rd_addr  = '0;
      act_wr_en    = 1'b0;
      act_wr_addr  = '0;
      act_wr_data  = '0;
      weights      = '0;
      inputs       = '0;
      accumulate   = 1'b0;
      done         = 1'b0;
      clear        = 1'b1;
    end

    bias_first_d = (state_d == ST_BIAS) && (state_q != ST_BIAS);
  end

  assign flash_addr = flash_addr_q;
  assign bias       = bias_q;
  assign busy       = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      k_q          <= '0;
      chunks_q     <= '0;
      ninp_q       <= '0;
      nneu_q       <= '0;
      in_base_q    <= '0;
      out_base_q   <= '0;
      flash_addr_q <= '0;
      weights_q    <= '0;
      bias_q       <= '0;
      bias_first_q <= 1'b0;
      wr_phase_q   <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      k_q          <= k_d;
      chunks_q     <= chunks_d;
      ninp_q       <= ninp_d;
      nneu_q       <= nneu_d;
      in_base_q    <= in_base_d;
      out_base_q   <= out_base_d;
      flash_addr_q <= flash_addr_d;
      weights_q    <= weights_d;
      bias_q       <= bias_d;
      bias_first_q <= bias_first_d;
      wr_phase_q   <= wr_phase_d;
      zero_q       <= zero_d;
    end
  end

endmodule

// File: doc/network_sequencer.md
NETWORK_SEQUENCER -- requirements
Module: network_sequencer

Interface
REQ-001 Parameters (name, default, meaning):
- LANES, 4, MAC lanes per step
- DATA_W, 4, weight/input/bias/result width
- FADDR_W, 16, flash address width
- AADDR_W, 5, activation memory address width
- CNT_W, 8, width of input/neuron count fields
REQ-002 Ports (name direction width meaning); clock and reset are clk and rst, one clock domain, reset synchronous and active-high:
- clk in 1: clock, rising edge
- rst in 1: synchronous active-high reset
- start in 1: single-cycle layer start pulse
- abort in 1: cancel current layer
- num_inputs in CNT_W: inputs per neuron, 1..2^CNT_W-1
- num_neurons in CNT_W: neurons in layer, 1..2^CNT_W-1
- weight_base in FADDR_W: first flash word of layer
- in_base in AADDR_W: first activation-memory word of layer inputs
- out_base in AADDR_W: first activation-memory word for outputs
- flash_req out 1: flash read request
- flash_addr out FADDR_W: flash word address
- flash_valid in 1: flash_data valid (word accepted)
- flash_data in LANES*DATA_W: LANES weights, lane 0 in LSBs
- act_rd_addr out AADDR_W: activation read address
- act_rd_data in LANES*DATA_W: activations, fixed 1-cycle read latency
- act_wr_en out 1: activation write strobe
- act_wr_addr out AADDR_W: activation write address
- act_wr_data out DATA_W: neuron result
- weights out LANES*DATA_W: weights to MAC
- inputs out LANES*DATA_W: inputs to MAC
- bias out DATA_W: bias to MAC
- clear out 1: zero MAC accumulator
- accumulate out 1: MAC adds weights*inputs this cycle
- mac_result in DATA_W: activated MAC output, valid 1 cycle after last accumulate
- busy out 1: layer in progress
- done out 1: single-cycle layer complete pulse

Function
REQ-003 States: IDLE, BIAS, FETCH, ACCUM, WRITE, DONE.
REQ-004 IDLE: start=1 -> capture num_inputs, num_neurons, bases; neuron counter n=0, chunk counter k=0; flash_addr=weight_base; go to BIAS.
REQ-005 CHUNKS = ceil(num_inputs/LANES); flash layout per neuron: one bias word (bias in lane 0 bits) then CHUNKS weight words, contiguous; flash_addr increments by 1 per accepted word, never recomputed.
REQ-006 BIAS: flash_req=1, clear=1 on first cycle of state; on flash_valid latch bias=flash_data[DATA_W-1:0], flash_addr+1, act_rd_addr=in_base+0, go to FETCH.
REQ-007 FETCH: flash_req=1, act_rd_addr=in_base+k; on flash_valid latch weights, flash_addr+1, go to ACCUM.
REQ-008 Flash may hold flash_valid low indefinitely; flash_req and flash_addr held stable until flash_valid.
REQ-009 ACCUM: exactly one cycle, accumulate=1, inputs=act_rd_data masked; k+1; if k=CHUNKS-1 go to WRITE else FETCH.
REQ-010 Masking: on last chunk, lanes with index >= num_inputs - k*LANES drive weights and inputs 0.
REQ-011 WRITE: one wait cycle, then act_wr_en=1 for one cycle, act_wr_addr=out_base+n, act_wr_data=mac_result; n+1, k=0; n=num_neurons-1 -> DONE else BIAS.
REQ-012 DONE: done=1 one cycle, busy=0 next cycle, return IDLE.
REQ-013 busy=1 in every state except IDLE.
REQ-014 start while busy ignored; config inputs sampled only at accepted start.
REQ-015 abort (any non-IDLE state) -> IDLE next cycle, clear=1 that cycle, no act_wr_en, no done; abort has priority over flash_valid same cycle; abort in IDLE ignored.
REQ-016 Address arithmetic wraps modulo 2^width (flash_addr, act_rd_addr, act_wr_addr); no error flag.
REQ-017 num_inputs=0 or num_neurons=0 at start: go directly to DONE, no flash or memory access.
REQ-018 clear, accumulate, act_wr_en, done, flash_req are mutually consistent: accumulate and clear never both 1.

Reset
REQ-019 rst=1 at clk edge -> state IDLE, all counters 0, all outputs 0 (flash_addr, act_rd_addr, act_wr_addr, weights, inputs, bias 0) next cycle; mid-layer reset discards layer, no done.

Verification
REQ-020 num_inputs=4, num_neurons=1, flash_valid always 1, weight word 0x1111, bias 0x2 -> one ACCUM, one write at out_base, done 6 cycles after start.
REQ-021 num_inputs=6, LANES=4 -> 2 ACCUM per neuron; second chunk lanes 2,3 weights/inputs 0.
REQ-022 num_neurons=3, num_inputs=8, weight_base=0x0100 -> flash_addr sequence 0x0100..0x0108, writes out_base+0..2, single done.
REQ-023 flash_valid withheld 5 cycles in FETCH -> flash_addr stable, accumulate 0, then resume; result unchanged.
REQ-024 abort during second ACCUM/FETCH of 3-neuron layer -> IDLE next cycle, no further act_wr_en, done never asserted; new start runs cleanly.
REQ-025 rst asserted mid-FETCH -> all outputs 0 next cycle; start while busy ignored; num_inputs=0 -> done 2 cycles after start, flash_req never 1.
